hazard_bypass_unit: RTL

//  Pipeline hazard controller; source of the Ex-stage bypass selects (ALUSrcA/B_ByPassing).

---
 rtl/hazard_bypass_unit_pkg.sv | 24 ++
 rtl/hazard_sat_counter.sv | 22 ++
 rtl/hazard_bypass_unit.sv | 101 ++++++++++
 3 files changed

// File: rtl/hazard_bypass_unit_pkg.sv
// rtl/hazard_bypass_unit_pkg.sv - shared bypass select codes, FSM states and select priority helper
package hazard_bypass_unit_pkg;

  localparam logic [1:0] BYP_REG   = 2'b00;
  localparam logic [1:0] BYP_EXMEM = 2'b01;
  localparam logic [1:0] BYP_MEMWR = 2'b10;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_LSTALL = 1'b1
  } hz_state_e;

  // Youngest producer wins: an Ex-stage match shadows a Mem-stage match.
  function automatic logic [1:0] byp_pick(input logic ex_hit, input logic mem_hit);
    logic [1:0] sel;
    sel = BYP_REG;
    if (ex_hit)
      sel = BYP_EXMEM;
    else if (mem_hit)
      sel = BYP_MEMWR;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_sat_counter.sv
// rtl/hazard_sat_counter.sv - saturating event counter with freeze input
module hazard_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             hold,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (!hold && inc && (cnt != CNT_MAX))
      cnt <= cnt + CNT_ONE;
  end

endmodule

// File: rtl/hazard_bypass_unit.sv
// rtl/hazard_bypass_unit.sv - forwarding select, load-use stall and branch flush control
module hazard_bypass_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs_Id,
  input  logic [REG_AW-1:0] Rt_Id,
  input  logic              UseRs_Id,
  input  logic              UseRt_Id,
  input  logic [REG_AW-1:0] Reg_Target_Ex,
  input  logic              RegWr_Ex,
  input  logic              MemToReg_Ex,
  input  logic              BrTaken_Ex,
  input  logic              Jump_Ex,
  input  logic              Stall_Ext,
  output logic [1:0]        ALUSrcA_ByPassing,
  output logic [1:0]        ALUSrcB_ByPassing,
  output logic              Stall_PC,
  output logic              Stall_IfId,
  output logic              Bubble_IdEx,
  output logic              Flush_IfId,
  output logic [CNT_W-1:0]  Stall_Cnt,
  output logic [CNT_W-1:0]  Flush_Cnt
);
  import hazard_bypass_unit_pkg::*;

  hz_state_e         state;
  logic [REG_AW-1:0] mem_dst;
  logic              mem_wr;
  logic              ex_alu_wr, ex_load_wr;
  logic              flush, lu, active, stall_req, flush_req;
  logic [1:0]        next_sel_a, next_sel_b;

  // Register 0 is hardwired, so it never matches a producer.
  function automatic logic src_hit(input logic use_x, input logic [REG_AW-1:0] x,
                                   input logic wr, input logic [REG_AW-1:0] dst);
    return use_x & wr & (x != '0) & (x == dst);
  endfunction

  assign ex_alu_wr  = RegWr_Ex & ~MemToReg_Ex;
  assign ex_load_wr = RegWr_Ex & MemToReg_Ex;

  assign next_sel_a = byp_pick(src_hit(UseRs_Id, Rs_Id, ex_alu_wr, Reg_Target_Ex),
                               src_hit(UseRs_Id, Rs_Id, mem_wr, mem_dst));
  assign next_sel_b = byp_pick(src_hit(UseRt_Id, Rt_Id, ex_alu_wr, Reg_Target_Ex),
                               src_hit(UseRt_Id, Rt_Id, mem_wr, mem_dst));

  assign lu    = src_hit(UseRs_Id, Rs_Id, ex_load_wr, Reg_Target_Ex)
               | src_hit(UseRt_Id, Rt_Id, ex_load_wr, Reg_Target_Ex);
  assign flush = BrTaken_Ex | Jump_Ex;

  // A frozen pipeline or a reset in progress silences every control output.
  assign active    = ~rst & ~Stall_Ext;
  assign flush_req = active & flush;
  assign stall_req = active & ~flush & lu & (state == ST_RUN);

  assign Stall_PC    = stall_req;
  assign Stall_IfId  = stall_req;
  assign Bubble_IdEx = stall_req | flush_req;
  assign Flush_IfId  = flush_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= ST_RUN;
      mem_dst           <= '0;
      mem_wr            <= 1'b0;
      ALUSrcA_ByPassing <= BYP_REG;
      ALUSrcB_ByPassing <= BYP_REG;
    end else if (!Stall_Ext) begin
      mem_dst           <= Reg_Target_Ex;
      mem_wr            <= RegWr_Ex & (Reg_Target_Ex != '0);
      ALUSrcA_ByPassing <= Bubble_IdEx ? BYP_REG : next_sel_a;
      ALUSrcB_ByPassing <= Bubble_IdEx ? BYP_REG : next_sel_b;
      // The held consumer picks up the load from Mem one cycle later via the Mem-match path.
      case (state)
        ST_RUN:    if (stall_req) state <= ST_LSTALL;
        ST_LSTALL: state <= ST_RUN;
        default:   state <= ST_RUN;
      endcase
    end
  end

  hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (stall_req),
    .hold (Stall_Ext),
    .cnt  (Stall_Cnt)
  );

  hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (flush_req),
    .hold (Stall_Ext),
    .cnt  (Flush_Cnt)
  );

endmodule
